shift_add_multiplier_32: RTL
============================

// Module: shift_add_multiplier_32
// PURPOSE
//   Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier.
//   It is the downstream consumer of the 32-bit ripple carry adder. It instantiates RCA_32bit
//   (a, b, c -> S, C) once and reuses it every cycle to add the multiplicand into the upper
//   product half. It is the next datapath block built on the adder in the lab series.
// PARAMETERS
//   WIDTH   32   operand width; the product is 2*WIDTH. Only 32 is supported while RCA_32bit is the adder.
//   CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH.
// PORTS
//   clk      in   1        single clock, rising edge
//   rst      in   1        asynchronous, active-high reset
//   start    in   1        request to begin a multiply; sampled only while ready=1
//   a        in   WIDTH    multiplicand, unsigned
//   b        in   WIDTH    multiplier, unsigned
//   ready    out  1        1 in IDLE only; a start is accepted only when ready=1
//   busy     out  1        1 in RUN only
//   done     out  1        one-cycle pulse: product holds the new result
//   product  out  2*WIDTH  result register; holds its value until the next accepted start or reset
// BEHAVIOUR
//   Reset (rst=1, async): state=IDLE, product=0, counter=0, multiplicand reg=0.
//     Outputs during reset: ready=1, busy=0, done=0. A reset mid-RUN aborts the operation:
//     no done pulse, product=0.
//   State machine (registered), IDLE -> RUN -> DONE -> IDLE:
//     IDLE: on an edge with start=1, latch M<=a and P<={WIDTH'b0, b}, set counter=0, go to RUN.
//           The inputs a and b are don't-care after that edge.
//     RUN:  every edge performs one iteration:
//             {cy, s} = RCA_32bit(P[2W-1:W], P[0] ? M : 0, c=0)
//             P <= {cy, s, P[W-1:1]}
//             counter <= counter + 1
//           Go to DONE after the iteration with counter==WIDTH-1, i.e. exactly WIDTH RUN cycles.
//     DONE: exactly one cycle with done=1. product = P is final. Go to IDLE on the next edge.
//   Latency: start is accepted at edge k. done is high in the cycle after edge k+WIDTH,
//     i.e. WIDTH+1 cycles after acceptance. Throughput is one multiply per WIDTH+2 cycles.
//   Carry rule: the adder carry-out becomes bit 2W-1 after the shift. No overflow is possible;
//     the full 2*WIDTH result is exact and the product never wraps.
//   Ignored inputs:
//     - start while busy=1 or in DONE. Operands are not re-latched and the operation in flight
//       is unaffected.
//     - start held high continuously: a new multiply is accepted on the first IDLE edge after
//       DONE, so consecutive results are back-to-back with a one-cycle IDLE gap.
//   Combinational decode: ready, busy and done decode the state register directly, with no
//     extra latency. product is driven directly from P.
//   During RUN, product shows the partial value P. Consumers sample product only when done=1,
//     or afterwards in IDLE.
//   Zero operand: a=0 or b=0 still takes the full WIDTH cycles and yields 0. There is no early exit.
// TESTING
//   1. a=4294967295, b=4294967295, start pulse -> busy for 32 cycles, then done for 1 cycle,
//      product=64'hFFFFFFFE00000001.
//   2. a=231, b=25 -> product=5775. a=0, b=123 -> product=0 after the full 32-cycle latency.
//   3. a=42400000, b=429 -> product=18189600000. Check product still holds 18189600000
//      10 cycles after done with start=0.
//   4. Start accepted with a=3, b=5. Pulse start with a=7, b=9 during RUN cycle 4 -> ignored;
//      product=15. Exactly one done pulse.
//   5. Start held at 1 with a=2, b=3 -> done every 34 cycles, product=6 each time.
//      ready is high for exactly 1 cycle between operations.
//   6. Assert rst during RUN cycle 10 -> ready=1, busy=0, product=0 immediately and no done.
//      After release, a=4294000000, b=2 -> product=8588000000.

Source files
------------

// File: rtl/shift_add_multiplier_32.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier.
// A single RCA_32bit adder is reused every RUN cycle to accumulate the multiplicand.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module RCA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c,
    output logic [31:0] S,
    output logic        C
);
    logic [32:0] carry;

    assign carry[0] = c;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .s   (S[i]),
            .cout(carry[i+1])
        );
    end

    assign C = carry[32];
endmodule

module shift_add_multiplier_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               step;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;

    // Multiplier bit 0 sits at p[0]; it selects whether this iteration adds M.
    assign addend = p[0] ? m : '0;

    RCA_32bit u_rca (
        .a(p[2*WIDTH-1:WIDTH]),
        .b(addend),
        .c(1'b0),
        .S(sum),
        .C(carry)
    );

    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            p     <= '0;
            m     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                m   <= a;
                p   <= {{WIDTH{1'b0}}, b};
                cnt <= '0;
            end else if (step) begin
                // The adder carry-out lands in the top bit after the shift, so nothing is lost.
                p   <= {carry, sum, p[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign ready   = (state == IDLE);
    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign product = p;

endmodule
